// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_WELCOME    = 3'd0,
        ST_PLAY       = 3'd1,
        ST_PAUSED     = 3'd2,
        ST_LEVEL_DONE = 3'd3,
        ST_GAME_OVER  = 3'd4,
        ST_WIN        = 3'd5
    } game_state_t;

    localparam int BALL_TYPE_W        = 2;
    // presentType value that grants an extra life; k>0 selects power-up channel k-1
    localparam int PRESENT_EXTRA_LIFE = 0;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of play-field event inputs and game status outputs.
interface game_flow_ctrl_if #(
    parameter int NUM_LEVELS   = 4,
    parameter int MAX_LIVES    = 4,
    parameter int NUM_POWERUPS = 3,
    parameter int SCORE_W      = 16,
    parameter int TIME_W       = 12
);
    import game_pkg::*;

    logic                                startKey;
    logic                                pauseKey;
    logic                                secTick;
    logic                                colPlayerBall;
    logic                                colRopeBall;
    logic                                colPresent;
    logic [BALL_TYPE_W-1:0]              ballType;
    logic [$clog2(NUM_POWERUPS+1)-1:0]   presentType;
    logic                                levelCleared;

    logic [2:0]                          gameState;
    logic [$clog2(NUM_LEVELS)-1:0]       level;
    logic [$clog2(MAX_LIVES+1)-1:0]      lives;
    logic [SCORE_W-1:0]                  score;
    logic [TIME_W-1:0]                   gameTime;
    logic [NUM_POWERUPS-1:0]             powerupActive;
    logic                                playerReset;
    logic                                levelLoad;
    logic                                playEnable;

    // keyboard / collision side
    modport master (
        output startKey, pauseKey, secTick, colPlayerBall, colRopeBall, colPresent,
               ballType, presentType, levelCleared,
        input  gameState, level, lives, score, gameTime, powerupActive,
               playerReset, levelLoad, playEnable
    );

    // the controller itself
    modport slave (
        input  startKey, pauseKey, secTick, colPlayerBall, colRopeBall, colPresent,
               ballType, presentType, levelCleared,
        output gameState, level, lives, score, gameTime, powerupActive,
               playerReset, levelLoad, playEnable
    );
endinterface

// File: rtl/game_flow_ctrl_powerup_timer.sv
// One power-up countdown channel: active for exactly load_val ticks after a load.
module powerup_timer #(
    parameter int TMR_W = 3
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic             tick,
    input  logic             clear,
    input  logic [TMR_W-1:0] load_val,
    output logic             active,
    output logic [TMR_W-1:0] timer
);

    // clear > load > tick; a load on a tick cycle restarts the full count
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active <= 1'b0;
            timer  <= '0;
        end else if (clear) begin
            active <= 1'b0;
            timer  <= '0;
        end else if (load) begin
            active <= 1'b1;
            timer  <= load_val;
        end else if (tick && active) begin
            timer <= timer - TMR_W'(1);
            if (timer == TMR_W'(1))
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: state sequencing, lives/score/time/level and power-up channels.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int INITIAL_LIVES     = 3,
    parameter int MAX_LIVES         = 4,
    parameter int NUM_LEVELS        = 4,
    parameter int NUM_POWERUPS      = 3,
    parameter int PU_DURATION       = 5,
    parameter int HIT_IMMORTAL_SEC  = 3,
    parameter int LEVEL_PAUSE_SEC   = 2,
    parameter int SCORE_W           = 16,
    parameter int TIME_W            = 12,
    parameter int HIT_SCORE_QUANTUM = 10,
    parameter int LEVEL_BONUS       = 50
) (
    input  logic             clk,
    input  logic             resetN,
    game_flow_ctrl_if.slave  gf
);

    localparam int LVL_W   = $clog2(NUM_LEVELS);
    localparam int LIV_W   = $clog2(MAX_LIVES+1);
    localparam int PT_W    = $clog2(NUM_POWERUPS+1);
    localparam int TMR_MAX = (PU_DURATION > HIT_IMMORTAL_SEC) ? PU_DURATION : HIT_IMMORTAL_SEC;
    localparam int TMR_W   = $clog2(TMR_MAX+1);
    localparam int LDC_W   = $clog2(LEVEL_PAUSE_SEC+1);

    game_state_t        state, nxt_state;
    logic [LVL_W-1:0]   level_q, nxt_level;
    logic [LIV_W-1:0]   lives_q, nxt_lives, lives_after_hit;
    logic [SCORE_W-1:0] score_q, nxt_score, score_add;
    logic [SCORE_W:0]   score_sum;
    logic [TIME_W-1:0]  time_q, nxt_time;
    logic [LDC_W-1:0]   ld_cnt, nxt_ld_cnt;
    logic               start_q, start_qq, pause_q, pause_qq;
    logic               start_e, pause_e;
    logic               hit, lvl_load, pu_clear, pu_tick;
    logic               player_reset_q, level_load_q, play_en_q;

    logic [NUM_POWERUPS-1:0]             pu_load, pu_active;
    logic [NUM_POWERUPS-1:0][TMR_W-1:0]  pu_val, pu_timer;

    // key flops come out of reset high so a key held through reset gives no edge
    assign start_e = start_q & ~start_qq;
    assign pause_e = pause_q & ~pause_qq;

    // state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= ST_WELCOME;
        else         state <= nxt_state;
    end

    // next-state, counter updates and power-up control
    always_comb begin
        nxt_state       = state;
        nxt_level       = level_q;
        nxt_lives       = lives_q;
        nxt_time        = time_q;
        nxt_ld_cnt      = ld_cnt;
        score_add       = '0;
        lives_after_hit = lives_q;
        hit             = 1'b0;
        lvl_load        = 1'b0;
        pu_clear        = 1'b0;
        pu_tick         = 1'b0;
        pu_load         = '0;
        for (int k = 0; k < NUM_POWERUPS; k++)
            pu_val[k] = TMR_W'(PU_DURATION);

        case (state)
            ST_WELCOME: if (start_e) begin
                nxt_state = ST_PLAY;
                nxt_level = '0;
                nxt_lives = LIV_W'(INITIAL_LIVES);
                nxt_time  = '0;
                pu_clear  = 1'b1;
                lvl_load  = 1'b1;
            end
            ST_PLAY: begin
                pu_tick = gf.secTick;
                hit     = gf.colPlayerBall & ~pu_active[0];
                for (int k = 0; k < NUM_POWERUPS; k++)
                    pu_load[k] = gf.colPresent && (gf.presentType == PT_W'(k+1));
                // a simultaneous immortality present keeps its longer duration
                if (hit) begin
                    if (!pu_load[0]) pu_val[0] = TMR_W'(HIT_IMMORTAL_SEC);
                    pu_load[0] = 1'b1;
                end
                if (gf.secTick) begin
                    nxt_time  = time_q + TIME_W'(1);
                    score_add = SCORE_W'(1);
                end
                if (gf.colRopeBall)
                    score_add = score_add + SCORE_W'((int'(gf.ballType) + 1) * HIT_SCORE_QUANTUM);
                lives_after_hit = lives_q - LIV_W'(hit);
                if (gf.colPresent && gf.presentType == PT_W'(PRESENT_EXTRA_LIFE) &&
                    lives_after_hit < LIV_W'(MAX_LIVES))
                    nxt_lives = lives_after_hit + LIV_W'(1);
                else
                    nxt_lives = lives_after_hit;
                if (nxt_lives == '0) begin
                    nxt_state = ST_GAME_OVER;
                end else if (gf.levelCleared) begin
                    nxt_state  = ST_LEVEL_DONE;
                    nxt_ld_cnt = '0;
                    score_add  = score_add + SCORE_W'(LEVEL_BONUS * (int'(level_q) + 1));
                end else if (pause_e) begin
                    nxt_state = ST_PAUSED;
                end
            end
            ST_PAUSED: if (pause_e) nxt_state = ST_PLAY;
            ST_LEVEL_DONE: if (gf.secTick) begin
                if (ld_cnt == LDC_W'(LEVEL_PAUSE_SEC-1)) begin
                    if (level_q == LVL_W'(NUM_LEVELS-1)) begin
                        nxt_state = ST_WIN;
                    end else begin
                        nxt_state = ST_PLAY;
                        nxt_level = level_q + LVL_W'(1);
                        pu_clear  = 1'b1;
                        lvl_load  = 1'b1;
                    end
                end else begin
                    nxt_ld_cnt = ld_cnt + LDC_W'(1);
                end
            end
            ST_GAME_OVER, ST_WIN: if (start_e) nxt_state = ST_WELCOME;
            default: nxt_state = ST_WELCOME;
        endcase

        // score saturates rather than wrapping; a game start clears it
        score_sum = {1'b0, score_q} + {1'b0, score_add};
        if (state == ST_WELCOME && start_e) nxt_score = '0;
        else if (score_sum[SCORE_W])        nxt_score = '1;
        else                                nxt_score = score_sum[SCORE_W-1:0];
    end

    // counters, key history and registered pulses
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            level_q        <= '0;
            lives_q        <= LIV_W'(INITIAL_LIVES);
            score_q        <= '0;
            time_q         <= '0;
            ld_cnt         <= '0;
            start_q        <= 1'b1;
            start_qq       <= 1'b1;
            pause_q        <= 1'b1;
            pause_qq       <= 1'b1;
            player_reset_q <= 1'b0;
            level_load_q   <= 1'b0;
            play_en_q      <= 1'b0;
        end else begin
            level_q        <= nxt_level;
            lives_q        <= nxt_lives;
            score_q        <= nxt_score;
            time_q         <= nxt_time;
            ld_cnt         <= nxt_ld_cnt;
            start_q        <= gf.startKey;
            start_qq       <= start_q;
            pause_q        <= gf.pauseKey;
            pause_qq       <= pause_q;
            player_reset_q <= hit;
            level_load_q   <= lvl_load;
            play_en_q      <= (nxt_state == ST_PLAY);
        end
    end

    for (genvar g = 0; g < NUM_POWERUPS; g++) begin : g_pu
        powerup_timer #(.TMR_W(TMR_W)) u_pu (
            .clk      (clk),
            .resetN   (resetN),
            .load     (pu_load[g]),
            .tick     (pu_tick),
            .clear    (pu_clear),
            .load_val (pu_val[g]),
            .active   (pu_active[g]),
            .timer    (pu_timer[g])
        );
    end

    assign gf.gameState     = state;
    assign gf.level         = level_q;
    assign gf.lives         = lives_q;
    assign gf.score         = score_q;
    assign gf.gameTime      = time_q;
    assign gf.powerupActive = pu_active;
    assign gf.playerReset   = player_reset_q;
    assign gf.levelLoad     = level_load_q;
    assign gf.playEnable    = play_en_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a behavioural model queues the expected
// outputs for every clock, a monitor pops and compares them after each edge.
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .gf     (bus)
    );

    typedef struct {
        int st; int lvl; int lives; int score; int tm; int pu; int pr; int ll; int pe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // model state
    int m_st, m_lvl, m_lives, m_score, m_tm, m_ldc;
    int m_act[3];
    int m_tmr[3];
    bit m_pr, m_ll, m_pe;
    bit m_ks, m_kss, m_kp, m_kpp;
    int saved;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_lvl = 0; m_lives = 3; m_score = 0; m_tm = 0; m_ldc = 0;
        for (int k = 0; k < 3; k++) begin m_act[k] = 0; m_tmr[k] = 0; end
        m_pr = 0; m_ll = 0; m_pe = 0;
        m_ks = 1; m_kss = 1; m_kp = 1; m_kpp = 1;
    endtask

    task automatic model_clear_pu();
        for (int k = 0; k < 3; k++) begin m_act[k] = 0; m_tmr[k] = 0; end
    endtask

    // one clock of the expected behaviour, from inputs held during the cycle
    task automatic model_step();
        bit se, pe, tick, hit, ld;
        int add, nl, ldv;
        se   = m_ks && !m_kss;
        pe   = m_kp && !m_kpp;
        tick = bus.secTick;
        m_pr = 0; m_ll = 0;
        case (m_st)
            0: if (se) begin
                m_st = 1; m_score = 0; m_tm = 0; m_lvl = 0; m_lives = 3;
                model_clear_pu(); m_ll = 1;
            end
            1: begin
                add = 0;
                hit = bus.colPlayerBall && (m_act[0] == 0);
                if (tick) begin m_tm = (m_tm + 1) % 4096; add = add + 1; end
                if (bus.colRopeBall) add = add + (int'(bus.ballType) + 1) * 10;
                nl = m_lives - int'(hit);
                if (bus.colPresent && bus.presentType == 0 && nl < 4) nl = nl + 1;
                for (int k = 0; k < 3; k++) begin
                    ld  = bus.colPresent && (int'(bus.presentType) == k + 1);
                    ldv = 5;
                    if (k == 0 && hit) begin
                        if (!ld) ldv = 3;
                        ld = 1;
                    end
                    if (ld) begin m_act[k] = 1; m_tmr[k] = ldv; end
                    else if (tick && m_act[k] == 1) begin
                        m_tmr[k] = m_tmr[k] - 1;
                        if (m_tmr[k] == 0) m_act[k] = 0;
                    end
                end
                m_pr = hit;
                m_lives = nl;
                if (nl == 0) m_st = 4;
                else if (bus.levelCleared) begin
                    add = add + 50 * (m_lvl + 1); m_st = 3; m_ldc = 0;
                end else if (pe) m_st = 2;
                m_score = (m_score + add > 65535) ? 65535 : m_score + add;
            end
            2: if (pe) m_st = 1;
            3: if (tick) begin
                if (m_ldc == 1) begin
                    if (m_lvl == 3) m_st = 5;
                    else begin m_lvl++; model_clear_pu(); m_ll = 1; m_st = 1; end
                end else m_ldc++;
            end
            default: if (se) m_st = 0;
        endcase
        m_pe  = (m_st == 1);
        m_kss = m_ks; m_ks = bus.startKey;
        m_kpp = m_kp; m_kp = bus.pauseKey;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st = m_st; e.lvl = m_lvl; e.lives = m_lives; e.score = m_score; e.tm = m_tm;
        e.pu = m_act[0] | (m_act[1] << 1) | (m_act[2] << 2);
        e.pr = int'(m_pr); e.ll = int'(m_ll); e.pe = int'(m_pe);
        return e;
    endfunction

    // advance one clock: model predicts, expectation is queued, pulses drop
    task automatic step();
        @(posedge clk);
        model_step();
        sb.push_back(snap());
        #2;
        bus.secTick = 0; bus.colPlayerBall = 0; bus.colRopeBall = 0;
        bus.colPresent = 0; bus.levelCleared = 0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin bus.secTick = 1; step(); end
    endtask

    task automatic press_start();
        bus.startKey = 1; step(); step(); bus.startKey = 0; step();
    endtask

    task automatic press_pause();
        bus.pauseKey = 1; step(); step(); bus.pauseKey = 0; step();
    endtask

    task automatic clear_level();
        bus.levelCleared = 1; step();
        tick_n(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, bus.gameState, 0);
        chk({tag, "_lives"}, bus.lives, 3);
        chk({tag, "_score"}, bus.score, 0);
        chk({tag, "_time"},  bus.gameTime, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_pu"},    bus.powerupActive, 0);
        chk({tag, "_pr"},    bus.playerReset, 0);
        chk({tag, "_ll"},    bus.levelLoad, 0);
        chk({tag, "_pe"},    bus.playEnable, 0);
    endtask

    // compare every queued expectation shortly after the edge it belongs to
    always @(posedge clk) begin
        #1;
        if (resetN && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("state", bus.gameState, mon_e.st);
            chk("level", bus.level, mon_e.lvl);
            chk("lives", bus.lives, mon_e.lives);
            chk("score", bus.score, mon_e.score);
            chk("gameTime", bus.gameTime, mon_e.tm);
            chk("powerupActive", bus.powerupActive, mon_e.pu);
            chk("playerReset", bus.playerReset, mon_e.pr);
            chk("levelLoad", bus.levelLoad, mon_e.ll);
            chk("playEnable", bus.playEnable, mon_e.pe);
        end
    end

    initial begin
        bus.startKey = 1; bus.pauseKey = 0; bus.secTick = 0;
        bus.colPlayerBall = 0; bus.colRopeBall = 0; bus.colPresent = 0;
        bus.ballType = 0; bus.presentType = 0; bus.levelCleared = 0;
        model_reset();
        #23;
        chk_reset_outputs("reset");
        @(negedge clk);
        resetN = 1;

        // start key held through reset must not start the game
        repeat (3) step();
        chk("held_key_no_start", bus.gameState, 0);
        bus.startKey = 0; step();

        // key held 3 cycles: one PLAY entry
        bus.startKey = 1; repeat (3) step(); bus.startKey = 0; repeat (2) step();
        chk("start_play", bus.gameState, 1);
        chk("start_lives", bus.lives, 3);
        chk("start_score", bus.score, 0);

        // 5 seconds then a size-2 ball hit
        repeat (5) begin bus.secTick = 1; step(); step(); end
        bus.colRopeBall = 1; bus.ballType = 2; step();
        chk("time_after_5", bus.gameTime, 5);
        chk("score_35", bus.score, 35);

        // hit, second hit while immortal is ignored, immortality lasts 3 ticks
        bus.colPlayerBall = 1; step();
        chk("hit1_lives", bus.lives, 2);
        step(); tick_n(1);
        bus.colPlayerBall = 1; step();
        chk("hit2_ignored", bus.lives, 2);
        tick_n(1);
        chk("immortal_tick2", bus.powerupActive[0], 1);
        tick_n(1);
        chk("immortal_expired", bus.powerupActive[0], 0);
        bus.colPlayerBall = 1; step();
        chk("hit3_lives", bus.lives, 1);

        // pause mid-immortality: everything frozen, timers resume afterwards
        tick_n(1);
        press_pause();
        chk("paused", bus.gameState, 2);
        saved = int'(bus.score);
        tick_n(10);
        bus.colPlayerBall = 1; step();
        bus.startKey = 1; step(); step(); bus.startKey = 0; step();
        chk("pause_lives", bus.lives, 1);
        chk("pause_score", bus.score, saved);
        chk("pause_still", bus.gameState, 2);
        press_pause();
        chk("resumed", bus.gameState, 1);
        tick_n(1);
        chk("resume_imm_on", bus.powerupActive[0], 1);
        tick_n(1);
        chk("resume_imm_off", bus.powerupActive[0], 0);

        // presents: extra life, channel 1 and 2, then hit + extra life together
        bus.colPresent = 1; bus.presentType = 0; step();
        bus.colPresent = 1; bus.presentType = 2; step();
        bus.colPresent = 1; bus.presentType = 3; tick_n(1);
        chk("pu_channels", bus.powerupActive, 3'b110);
        bus.colPlayerBall = 1; bus.colPresent = 1; bus.presentType = 0; step();
        chk("hit_plus_life", bus.lives, 2);
        chk("hit_plus_life_pr", bus.playerReset, 1);

        // clear levels 0..2, then the last level leads to WIN
        repeat (3) clear_level();
        chk("at_level3", bus.level, 3);
        saved = int'(bus.score);
        bus.levelCleared = 1; step();
        chk("last_bonus", bus.score, saved + 200);
        tick_n(1);
        chk("level_done_hold", bus.gameState, 3);
        tick_n(1);
        chk("win", bus.gameState, 5);
        press_start();
        chk("win_to_welcome", bus.gameState, 0);

        // new game: extra life saturates at 4
        press_start(); step();
        repeat (3) begin bus.colPresent = 1; bus.presentType = 0; step(); end
        chk("lives_cap", bus.lives, 4);

        // lose lives down to 1, then lose the last one while clearing the level
        repeat (3) begin bus.colPlayerBall = 1; step(); tick_n(3); end
        chk("lives_one", bus.lives, 1);
        saved = int'(bus.score);
        bus.colPlayerBall = 1; bus.levelCleared = 1; step();
        chk("game_over", bus.gameState, 4);
        chk("game_over_no_bonus", bus.score, saved);
        tick_n(3);
        chk("game_over_hold_time", bus.gameState, 4);

        // asynchronous reset mid-game
        press_start(); press_start(); tick_n(2);
        bus.colRopeBall = 1; bus.ballType = 3; step();
        resetN = 0;
        sb.delete();
        model_reset();
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        resetN = 1;
        repeat (3) step();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
